// File: rtl/l2_mem_responder.sv
// l2_mem_responder: block-granular main memory below the L2 cache.
// One request in flight at a time. An open-row buffer picks the latency:
// row hits finish on mem_hit after ROW_HIT_LAT cycles, misses on mem_ready
// after ROW_MISS_LAT cycles.
module l2_mem_responder #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned BLOCK_SIZE   = 16,
    parameter int unsigned MEM_BLOCKS   = 256,
    parameter int unsigned ROW_BLOCKS   = 4,
    parameter int unsigned ROW_HIT_LAT  = 2,
    parameter int unsigned ROW_MISS_LAT = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ADDR_WIDTH-1:0]                  mem_addr,
    input  logic                                   mem_read,
    input  logic                                   mem_write,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  mem_wdata,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  mem_rdata,
    output logic                                   mem_ready,
    output logic                                   mem_hit
);

    localparam int unsigned OFF_W = $clog2(BLOCK_SIZE);
    localparam int unsigned IDX_W = (MEM_BLOCKS > 1) ? $clog2(MEM_BLOCKS) : 1;
    localparam int unsigned RB_W  = $clog2(ROW_BLOCKS);
    localparam int unsigned BLK_W = ADDR_WIDTH - OFF_W;
    localparam int unsigned ROW_W = BLK_W - RB_W;
    localparam int unsigned CNT_W = $clog2(ROW_MISS_LAT + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] blk_t;

    // Block storage; deliberately not reset.
    blk_t mem_q [MEM_BLOCKS];

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             op_wr_q,     op_wr_d;
    logic             rowhit_q,    rowhit_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    blk_t             wdata_q,     wdata_d;
    logic [ROW_W-1:0] open_row_q,  open_row_d;
    logic             row_valid_q, row_valid_d;
    blk_t             rdata_q,     rdata_d;
    logic             ready_q,     ready_d;
    logic             hit_q,       hit_d;

    logic [BLK_W-1:0] blk_c;
    logic [ROW_W-1:0] row_c;
    logic [IDX_W-1:0] idx_c;
    logic             mem_we_c;

    // Address decode: block number, storage index (aliases), full-width row.
    always_comb begin
        blk_c = BLK_W'(mem_addr >> OFF_W);
        row_c = ROW_W'(blk_c >> RB_W);
        idx_c = IDX_W'(blk_c);
    end

    // Next-state and datapath control for IDLE -> BUSY -> RESPOND.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        rowhit_d    = rowhit_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        open_row_d  = open_row_q;
        row_valid_d = row_valid_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        hit_d       = 1'b0;
        mem_we_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    // A simultaneous read+write is a write only.
                    op_wr_d     = mem_write;
                    rowhit_d    = row_valid_q && (row_c == open_row_q);
                    idx_d       = idx_c;
                    wdata_d     = mem_wdata;
                    open_row_d  = row_c;
                    row_valid_d = 1'b1;
                    cnt_d       = (row_valid_q && (row_c == open_row_q))
                                  ? CNT_W'(ROW_HIT_LAT) : CNT_W'(ROW_MISS_LAT);
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Last busy cycle: commit the access on the edge into RESPOND.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESPOND;
                    cnt_d   = '0;
                    hit_d   = rowhit_q;
                    ready_d = !rowhit_q;
                    if (op_wr_q) begin
                        mem_we_c = 1'b1;
                    end else begin
                        rdata_d = mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            rowhit_q    <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            open_row_q  <= '0;
            row_valid_q <= 1'b0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            rowhit_q    <= rowhit_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            open_row_q  <= open_row_d;
            row_valid_q <= row_valid_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            hit_q       <= hit_d;
        end
    end

    // Storage write port, fired only on the edge entering RESPOND.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_hit   = hit_q;

    // Completion pulses are exclusive and single-cycle.
    assert property (@(posedge clk) disable iff (rst) !(mem_hit && mem_ready));
    assert property (@(posedge clk) disable iff (rst)
                     (mem_hit || mem_ready) |=> !(mem_hit || mem_ready));

endmodule

// File: tb/tb_l2_mem_responder.sv
// Bench for l2_mem_responder: directed vector table, reset corner cases,
// then randomized traffic checked against a transaction-level memory model.
`timescale 1ns/1ps
module tb_l2_mem_responder;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned BS = 16;
    localparam int unsigned MB = 256;
    localparam int unsigned RB = 4;
    localparam int unsigned HL = 2;
    localparam int unsigned ML = 8;

    typedef logic [BS-1:0][DW-1:0] blk_t;

    typedef struct {
        logic [AW-1:0] addr;
        bit            rd;
        bit            wr;
        int unsigned   base;
        int            exp_lat;
        bit            exp_hit;
        bit            chk;
        int unsigned   exp_base;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic          mem_write;
    blk_t          mem_wdata;
    blk_t          mem_rdata;
    logic          mem_ready;
    logic          mem_hit;

    l2_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .MEM_BLOCKS(MB),
        .ROW_BLOCKS(RB), .ROW_HIT_LAT(HL), .ROW_MISS_LAT(ML)
    ) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_hit(mem_hit)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: sparse block store, open row, last read block.
    blk_t            m_mem [int];
    longint unsigned m_row;
    bit              m_row_valid;
    blk_t            m_rdata;
    bit              m_rdata_known;

    function automatic blk_t mk_blk(input int unsigned base);
        blk_t b;
        for (int i = 0; i < int'(BS); i++) b[i] = DW'(base + i);
        return b;
    endfunction

    function automatic blk_t rnd_blk();
        blk_t b;
        for (int i = 0; i < int'(BS); i++) b[i] = $urandom;
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_blk(input string name, input blk_t act, input blk_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_row_valid   = 1'b0;
        m_row         = 0;
        m_rdata       = '0;
        m_rdata_known = 1'b1;
    endtask

    task automatic model_apply(input logic [AW-1:0] addr, input bit rd, input bit wr,
                               input blk_t wd, output int lat, output bit hit,
                               output bit chk, output blk_t exp_rd);
        longint unsigned blk;
        longint unsigned row;
        int              idx;
        blk = longint'(addr) / BS;
        idx = int'(blk % MB);
        row = blk / RB;
        hit = m_row_valid && (row == m_row);
        lat = hit ? int'(HL) : int'(ML);
        m_row       = row;
        m_row_valid = 1'b1;
        if (wr) begin
            m_mem[idx] = wd;
        end else if (rd) begin
            if (m_mem.exists(idx)) begin
                m_rdata       = m_mem[idx];
                m_rdata_known = 1'b1;
            end else begin
                m_rdata_known = 1'b0;
            end
        end
        chk    = m_rdata_known;
        exp_rd = m_rdata;
    endtask

    // Issue one request as the L2 would: hold the level until a pulse, then drop.
    task automatic run_txn(input string tag, input logic [AW-1:0] addr, input bit rd,
                           input bit wr, input blk_t wd, input int exp_lat,
                           input bit exp_hit, input bit chk, input blk_t exp_rd,
                           input bit scramble);
        int lat_seen;
        bit got_hit;
        bit got_ready;
        blk_t got_rdata;
        lat_seen  = 0;
        got_hit   = 1'b0;
        got_ready = 1'b0;
        got_rdata = '0;
        mem_addr  = addr;
        mem_read  = rd;
        mem_write = wr;
        mem_wdata = wd;
        @(posedge clk); #1;
        for (int j = 1; j <= int'(ML) + 6; j++) begin
            if (scramble) begin
                mem_addr  = $urandom;
                mem_wdata = rnd_blk();
            end
            @(posedge clk); #1;
            if (mem_hit || mem_ready) begin
                lat_seen  = j;
                got_hit   = mem_hit;
                got_ready = mem_ready;
                got_rdata = mem_rdata;
                break;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (lat_seen == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no pulse within %0d cycles, expected at %0d",
                     tag, ML + 6, exp_lat);
            repeat (4) @(posedge clk);
            #1;
        end else begin
            check({tag, " latency"}, 64'(lat_seen), 64'(exp_lat));
            check({tag, " mem_hit"}, 64'(got_hit), 64'(exp_hit));
            check({tag, " mem_ready"}, 64'(got_ready), 64'(!exp_hit));
            if (chk) check_blk({tag, " rdata"}, got_rdata, exp_rd);
            @(posedge clk); #1;
            check({tag, " single pulse"}, 64'(mem_hit | mem_ready), 64'd0);
        end
    endtask

    // Table entry: keep the model in step, but check against the table's constants.
    task automatic run_vec(input string tag, input vec_t v);
        int   lat;
        bit   hit;
        bit   chk;
        blk_t erd;
        model_apply(v.addr, v.rd, v.wr, mk_blk(v.base), lat, hit, chk, erd);
        run_txn(tag, v.addr, v.rd, v.wr, mk_blk(v.base), v.exp_lat, v.exp_hit,
                v.chk, mk_blk(v.exp_base), 1'b0);
    endtask

    task automatic run_model(input string tag, input logic [AW-1:0] addr, input bit rd,
                             input bit wr, input blk_t wd, input bit scramble);
        int   lat;
        bit   hit;
        bit   chk;
        blk_t erd;
        model_apply(addr, rd, wr, wd, lat, hit, chk, erd);
        run_txn(tag, addr, rd, wr, wd, lat, hit, chk, erd, scramble);
    endtask

    vec_t tbl [10];

    initial begin
        int pulses;
        tbl[0] = '{32'h100,  1'b0, 1'b1, 32'hA0, 8, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{32'h100,  1'b1, 1'b0, 32'h0,  2, 1'b1, 1'b1, 32'hA0};
        tbl[2] = '{32'h200,  1'b1, 1'b1, 32'h55, 8, 1'b0, 1'b1, 32'hA0};
        tbl[3] = '{32'h200,  1'b1, 1'b0, 32'h0,  2, 1'b1, 1'b1, 32'h55};
        tbl[4] = '{32'h140,  1'b0, 1'b1, 32'h10, 8, 1'b0, 1'b1, 32'h55};
        tbl[5] = '{32'h130,  1'b1, 1'b0, 32'h0,  8, 1'b0, 1'b0, 32'h0};
        tbl[6] = '{32'h140,  1'b1, 1'b0, 32'h0,  8, 1'b0, 1'b1, 32'h10};
        tbl[7] = '{32'h14F,  1'b1, 1'b0, 32'h0,  2, 1'b1, 1'b1, 32'h10};
        tbl[8] = '{32'h1100, 1'b0, 1'b1, 32'hC0, 8, 1'b0, 1'b1, 32'h10};
        tbl[9] = '{32'h100,  1'b1, 1'b0, 32'h0,  8, 1'b0, 1'b1, 32'hC0};

        rst       = 1'b1;
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        model_reset();

        // Reset defaults, then 20 idle cycles with no pulse.
        repeat (3) @(posedge clk);
        #1;
        check("reset mem_ready", 64'(mem_ready), 64'd0);
        check("reset mem_hit", 64'(mem_hit), 64'd0);
        check_blk("reset mem_rdata", mem_rdata, '0);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (mem_hit || mem_ready) pulses++;
        end
        check("idle pulses", 64'(pulses), 64'd0);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset in the middle of a row-miss write leaves storage untouched.
        run_model("rst prep wr", 32'h300, 1'b0, 1'b1, mk_blk(32'h30), 1'b0);
        run_model("rst prep rd", 32'h100, 1'b1, 1'b0, '0, 1'b0);
        mem_addr  = 32'h300;
        mem_write = 1'b1;
        mem_wdata = mk_blk(32'h77);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("async rst mem_hit", 64'(mem_hit), 64'd0);
        check("async rst mem_ready", 64'(mem_ready), 64'd0);
        check_blk("async rst mem_rdata", mem_rdata, '0);
        @(posedge clk); #1;
        rst       = 1'b0;
        mem_write = 1'b0;
        model_reset();
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (mem_hit || mem_ready) pulses++;
        end
        check("aborted op pulses", 64'(pulses), 64'd0);
        run_model("post rst rd 0x300", 32'h300, 1'b1, 1'b0, '0, 1'b0);

        // Randomized traffic over a few rows, with aliasing and input churn.
        for (int n = 0; n < 40; n++) begin
            int unsigned   blk;
            int unsigned   op;
            logic [AW-1:0] a;
            blk = $urandom_range(0, 23) + (($urandom_range(0, 3) == 0) ? MB : 0);
            a   = AW'(blk * BS + $urandom_range(0, BS - 1));
            op  = $urandom_range(0, 2);
            run_model($sformatf("rnd%0d", n), a, op != 1, op != 0, rnd_blk(), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
